// File: rtl/bidir_serial_tx.sv
// Serialises a parallel word onto D/shift for the bidirectional shift register.
// Handshake accept in IDLE, WIDTH payload cycles in SHIFT, GAP_CYCLES idle cycles in GAP.
module bidir_serial_tx #(
    parameter int unsigned WIDTH      = 4,
    parameter int unsigned GAP_CYCLES = 1,
    parameter int unsigned CNT_W      = $clog2(WIDTH + GAP_CYCLES + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_dir,
    output logic             D,
    output logic             shift,
    output logic             bit_valid,
    output logic             busy,
    output logic             done
);

    localparam int unsigned BIT_LAST = WIDTH - 1;
    localparam int unsigned GAP_LAST = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_GAP   = 2'd2
    } state_t;

    state_t             r_state, w_nxt_state;
    logic [CNT_W-1:0]   r_cnt, w_nxt_cnt;
    logic [WIDTH-1:0]   r_shadow, w_nxt_shadow;
    logic               r_shift, w_nxt_shift;
    logic               r_d, w_nxt_d;
    logic               r_bit_valid, w_nxt_bit_valid;
    logic               r_busy, w_nxt_busy;
    logic               r_done, w_nxt_done;
    logic               r_in_ready, w_nxt_in_ready;

    // State and all outputs are registered together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_shadow    <= '0;
            r_shift     <= 1'b0;
            r_d         <= 1'b0;
            r_bit_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_in_ready  <= 1'b0;
        end else begin
            r_state     <= w_nxt_state;
            r_cnt       <= w_nxt_cnt;
            r_shadow    <= w_nxt_shadow;
            r_shift     <= w_nxt_shift;
            r_d         <= w_nxt_d;
            r_bit_valid <= w_nxt_bit_valid;
            r_busy      <= w_nxt_busy;
            r_done      <= w_nxt_done;
            r_in_ready  <= w_nxt_in_ready;
        end
    end

    // The shadow is shifted toward the emitting end, so the next bit is always
    // at a fixed position (WIDTH-2 for MSB-first, 1 for LSB-first).
    always_comb begin
        w_nxt_state     = r_state;
        w_nxt_cnt       = r_cnt;
        w_nxt_shadow    = r_shadow;
        w_nxt_shift     = r_shift;
        w_nxt_d         = 1'b0;
        w_nxt_bit_valid = 1'b0;
        w_nxt_busy      = 1'b0;
        w_nxt_done      = 1'b0;
        w_nxt_in_ready  = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (in_valid && r_in_ready) begin
                    w_nxt_state     = S_SHIFT;
                    w_nxt_shadow    = in_data;
                    w_nxt_shift     = in_dir;
                    w_nxt_cnt       = '0;
                    w_nxt_d         = in_dir ? in_data[WIDTH-1] : in_data[0];
                    w_nxt_bit_valid = 1'b1;
                    w_nxt_busy      = 1'b1;
                end else begin
                    w_nxt_in_ready  = 1'b1;
                end
            end
            S_SHIFT: begin
                if (r_cnt == CNT_W'(BIT_LAST)) begin
                    w_nxt_done = 1'b1;
                    w_nxt_cnt  = '0;
                    if (GAP_CYCLES > 0) begin
                        w_nxt_state = S_GAP;
                        w_nxt_busy  = 1'b1;
                    end else begin
                        w_nxt_state    = S_IDLE;
                        w_nxt_in_ready = 1'b1;
                    end
                end else begin
                    w_nxt_cnt       = r_cnt + CNT_W'(1);
                    w_nxt_shadow    = r_shift ? (r_shadow << 1) : (r_shadow >> 1);
                    w_nxt_d         = r_shift ? r_shadow[WIDTH-2] : r_shadow[1];
                    w_nxt_bit_valid = 1'b1;
                    w_nxt_busy      = 1'b1;
                end
            end
            S_GAP: begin
                if (r_cnt == CNT_W'(GAP_LAST)) begin
                    w_nxt_state    = S_IDLE;
                    w_nxt_cnt      = '0;
                    w_nxt_in_ready = 1'b1;
                end else begin
                    w_nxt_cnt  = r_cnt + CNT_W'(1);
                    w_nxt_busy = 1'b1;
                end
            end
            default: begin
                w_nxt_state = S_IDLE;
                w_nxt_cnt   = '0;
            end
        endcase
    end

    assign in_ready  = r_in_ready;
    assign D         = r_d;
    assign shift     = r_shift;
    assign bit_valid = r_bit_valid;
    assign busy      = r_busy;
    assign done      = r_done;

endmodule

// File: tb/tb_bidir_serial_tx.sv
// Directed bench for bidir_serial_tx: a WIDTH=4/GAP=1 instance and a WIDTH=8/GAP=0 instance.
module tb_bidir_serial_tx;

    logic       clk;
    logic       rst_n;
    logic       in_valid, in_dir;
    logic [3:0] in_data;
    logic       in_ready, d_o, shift_o, bit_valid, busy, done;

    logic       in_valid8, in_dir8;
    logic [7:0] in_data8;
    logic       in_ready8, d8, shift8, bit_valid8, busy8, done8;

    int n_vec;
    int n_err;

    bidir_serial_tx #(.WIDTH(4), .GAP_CYCLES(1)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_dir(in_dir),
        .D(d_o), .shift(shift_o), .bit_valid(bit_valid), .busy(busy), .done(done)
    );

    bidir_serial_tx #(.WIDTH(8), .GAP_CYCLES(0)) u_dut8 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid8), .in_ready(in_ready8), .in_data(in_data8), .in_dir(in_dir8),
        .D(d8), .shift(shift8), .bit_valid(bit_valid8), .busy(busy8), .done(done8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; sample point is 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a word and wait (bounded) until the accept edge has passed.
    task automatic send4(input logic [3:0] data, input logic dir);
        int budget;
        in_data  = data;
        in_dir   = dir;
        in_valid = 1'b1;
        budget   = 0;
        while (in_ready !== 1'b1 && budget < 20) begin
            tick();
            budget++;
        end
        n_vec++;
        if (in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL send4_ready_timeout: in_ready=%b required 1", in_ready);
        end
        tick();
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        in_valid = 1'b0; in_data = '0; in_dir = 1'b0;
        in_valid8 = 1'b0; in_data8 = '0; in_dir8 = 1'b0;
        repeat (3) tick();
        n_vec++;
        if ({in_ready, d_o, shift_o, bit_valid, busy, done} !== 6'b0) begin
            n_err++;
            $display("FAIL reset_outputs: got %b required 000000",
                     {in_ready, d_o, shift_o, bit_valid, busy, done});
        end
        rst_n = 1'b1;
        n_vec++;
        if (in_ready !== 1'b0) begin
            n_err++;
            $display("FAIL reset_ready_before_edge: in_ready=%b required 0", in_ready);
        end
        tick();
        n_vec++;
        if (in_ready !== 1'b1 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL reset_release: in_ready=%b busy=%b required 1 0", in_ready, busy);
        end
    endtask

    task automatic test_msb_first();
        logic [3:0] exp;
        exp = 4'b1011;
        send4(4'b1011, 1'b1);
        for (int i = 0; i < 4; i++) begin
            n_vec++;
            if ({d_o, bit_valid, shift_o, busy} !== {exp[3-i], 3'b111}) begin
                n_err++;
                $display("FAIL msb_bit%0d: D/bv/shift/busy=%b required %b", i,
                         {d_o, bit_valid, shift_o, busy}, {exp[3-i], 3'b111});
            end
            tick();
        end
        n_vec++;
        if ({done, bit_valid, busy, in_ready} !== 4'b1010) begin
            n_err++;
            $display("FAIL msb_gap: done/bv/busy/ready=%b required 1010",
                     {done, bit_valid, busy, in_ready});
        end
        tick();
        n_vec++;
        if ({done, in_ready, busy} !== 3'b010) begin
            n_err++;
            $display("FAIL msb_idle: done/ready/busy=%b required 010", {done, in_ready, busy});
        end
    endtask

    task automatic test_lsb_first();
        logic [3:0] exp;
        int dones;
        exp = 4'b1101;
        dones = 0;
        send4(4'b1011, 1'b0);
        for (int i = 0; i < 4; i++) begin
            n_vec++;
            if ({d_o, bit_valid, shift_o} !== {exp[3-i], 2'b10}) begin
                n_err++;
                $display("FAIL lsb_bit%0d: D/bv/shift=%b required %b", i,
                         {d_o, bit_valid, shift_o}, {exp[3-i], 2'b10});
            end
            if (done === 1'b1) dones++;
            tick();
        end
        for (int i = 0; i < 3; i++) begin
            if (done === 1'b1) dones++;
            tick();
        end
        n_vec++;
        if (dones != 1 || shift_o !== 1'b0) begin
            n_err++;
            $display("FAIL lsb_done_count: dones=%0d shift=%b required 1 0", dones, shift_o);
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] exp;
        int budget;
        exp = 4'b0110;
        send4(4'b0110, 1'b1);
        in_valid = 1'b1;
        in_data  = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            n_vec++;
            if ({d_o, bit_valid} !== {exp[3-i], 1'b1}) begin
                n_err++;
                $display("FAIL b2b_bit%0d: D/bv=%b required %b", i, {d_o, bit_valid},
                         {exp[3-i], 1'b1});
            end
            tick();
        end
        n_vec++;
        if ({done, in_ready, bit_valid} !== 3'b100) begin
            n_err++;
            $display("FAIL b2b_gap: done/ready/bv=%b required 100", {done, in_ready, bit_valid});
        end
        tick();
        n_vec++;
        if ({in_ready, bit_valid, done} !== 3'b100) begin
            n_err++;
            $display("FAIL b2b_idle: ready/bv/done=%b required 100", {in_ready, bit_valid, done});
        end
        tick();
        in_valid = 1'b0;
        n_vec++;
        if ({d_o, bit_valid, shift_o, in_ready} !== 4'b1110) begin
            n_err++;
            $display("FAIL b2b_second_first_bit: D/bv/shift/ready=%b required 1110",
                     {d_o, bit_valid, shift_o, in_ready});
        end
        budget = 0;
        while (in_ready !== 1'b1 && budget < 20) begin
            tick();
            budget++;
        end
        n_vec++;
        if (in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL b2b_drain_timeout: in_ready=%b required 1", in_ready);
        end
    endtask

    task automatic test_reset_mid_word();
        logic [3:0] exp;
        int dones;
        exp = 4'b0001;
        dones = 0;
        send4(4'b1011, 1'b1);
        tick();
        #1 rst_n = 1'b0;
        #1;
        n_vec++;
        if ({d_o, bit_valid, busy, shift_o, in_ready} !== 5'b0) begin
            n_err++;
            $display("FAIL midreset_async: D/bv/busy/shift/ready=%b required 00000",
                     {d_o, bit_valid, busy, shift_o, in_ready});
        end
        for (int i = 0; i < 2; i++) begin
            tick();
            if (done === 1'b1) dones++;
        end
        rst_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            if (done === 1'b1) dones++;
        end
        n_vec++;
        if (dones != 0 || in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL midreset_recover: dones=%0d ready=%b required 0 1", dones, in_ready);
        end
        send4(4'b1000, 1'b0);
        for (int i = 0; i < 4; i++) begin
            n_vec++;
            if ({d_o, bit_valid} !== {exp[3-i], 1'b1}) begin
                n_err++;
                $display("FAIL midreset_bit%0d: D/bv=%b required %b", i, {d_o, bit_valid},
                         {exp[3-i], 1'b1});
            end
            tick();
        end
        n_vec++;
        if (done !== 1'b1) begin
            n_err++;
            $display("FAIL midreset_done: done=%b required 1", done);
        end
        repeat (2) tick();
    endtask

    task automatic test_gap_zero();
        logic [7:0] exp;
        int budget;
        exp = 8'hA5;
        in_data8  = 8'hA5;
        in_dir8   = 1'b1;
        in_valid8 = 1'b1;
        budget = 0;
        while (in_ready8 !== 1'b1 && budget < 20) begin
            tick();
            budget++;
        end
        n_vec++;
        if (in_ready8 !== 1'b1) begin
            n_err++;
            $display("FAIL gap0_ready_timeout: in_ready=%b required 1", in_ready8);
        end
        tick();
        in_valid8 = 1'b0;
        for (int i = 0; i < 8; i++) begin
            n_vec++;
            if ({d8, bit_valid8, shift8, busy8} !== {exp[7-i], 3'b111}) begin
                n_err++;
                $display("FAIL gap0_bit%0d: D/bv/shift/busy=%b required %b", i,
                         {d8, bit_valid8, shift8, busy8}, {exp[7-i], 3'b111});
            end
            tick();
        end
        n_vec++;
        if ({done8, in_ready8, bit_valid8, busy8} !== 4'b1100) begin
            n_err++;
            $display("FAIL gap0_end: done/ready/bv/busy=%b required 1100",
                     {done8, in_ready8, bit_valid8, busy8});
        end
        tick();
        n_vec++;
        if ({done8, in_ready8} !== 2'b01) begin
            n_err++;
            $display("FAIL gap0_done_single: done/ready=%b required 01", {done8, in_ready8});
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        test_reset();
        test_msb_first();
        test_lsb_first();
        test_back_to_back();
        test_reset_mid_word();
        test_gap_zero();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/bidir_serial_tx.md
Name: bidir_serial_tx

Overview:
- Transmit-side driver for the team's bidirectional shift register.
- Accepts a parallel word plus a direction flag over a valid/ready handshake. Emits the word one bit per clock on a serial data line (D) with a matching direction line (shift).
- Sits between a parallel producer (FSM/testbench driver) and the D/shift inputs of the bidirectional register. It replaces hand-sequenced D/shift stimulus with a deterministic, framed bit stream.

Parameters:
- WIDTH, 4, bits per word (>=2).
- GAP_CYCLES, 1, idle cycles inserted after each word before the next accept (>=0).
- CNT_W, $clog2(WIDTH+GAP_CYCLES+1), internal counter width. Derived; do not override.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset, asynchronous, active-low.
- in_valid  input  1  producer has a word on in_data/in_dir.
- in_ready  output  1  block can accept a word this cycle.
- in_data  input  WIDTH  parallel word to send.
- in_dir  input  1  direction: 1 = MSB first, 0 = LSB first.
- D  output  1  serial data bit to the shift register.
- shift  output  1  direction line to the shift register; equals the captured in_dir.
- bit_valid  output  1  D carries a payload bit this cycle.
- busy  output  1  word in flight (SHIFT or GAP state).
- done  output  1  one-cycle pulse after the last bit of a word.

Behaviour:
- All outputs registered. The clock is the only timing source.
- Reset (rst_n=0, asynchronous): state=IDLE; D=0, shift=0, bit_valid=0, busy=0, done=0, in_ready=0; counter=0; data shadow=0.
- in_ready rises on the first clk edge after rst_n deasserts.
- States: IDLE, SHIFT, GAP.
- IDLE:
  - in_ready=1, busy=0, bit_valid=0, D=0.
  - Accept happens at an edge where in_valid=1 and in_ready=1. On accept: capture in_data into the shadow register and in_dir into shift; set counter=0; in_ready=0; go to SHIFT.
- SHIFT:
  - Lasts exactly WIDTH cycles, starting in the cycle after the accept edge (latency 1).
  - In cycle i (i=0..WIDTH-1): D = shadow[WIDTH-1-i] if shift=1, else shadow[i]. bit_valid=1, busy=1.
  - After cycle WIDTH-1: if GAP_CYCLES>0, go to GAP; else go to IDLE.
- GAP:
  - Lasts GAP_CYCLES cycles. D=0, bit_valid=0, busy=1, in_ready=0.
  - Then go to IDLE.
- done:
  - Pulses 1 in the single cycle immediately after the last SHIFT cycle. That cycle is the first GAP cycle, or the first IDLE cycle when GAP_CYCLES=0.
  - Never asserted for two consecutive cycles.
- shift holds the captured direction from accept until the next accept. It does not return to 0 in IDLE.
- in_valid, in_data and in_dir are ignored whenever in_ready=0. No queuing; the producer must hold in_valid until the handshake completes.
- Throughput: one word per WIDTH+GAP_CYCLES+1 cycles when in_valid is held high (the +1 is the IDLE accept cycle).
- Reset mid-word: outputs drop to reset values immediately (asynchronously). The partial word is discarded and done is not pulsed. After release, behaviour is identical to power-up.
- in_data changing after the accept edge has no effect on the word in flight.

Test Plan:
1. Hold rst_n=0 for 3 cycles -> all outputs 0. First edge after release -> in_ready=1, busy=0.
2. in_data=4'b1011, in_dir=1, in_valid pulsed for one handshake -> next 4 cycles: D=1,0,1,1, bit_valid=1, shift=1, busy=1. Cycle 5: done=1, bit_valid=0 (GAP). Cycle 6: in_ready=1.
3. in_data=4'b1011, in_dir=0 -> D=1,1,0,1 over 4 cycles, shift=0 throughout, done pulse once.
4. in_valid held high; word 4'b0110/dir=1 accepted, then in_data changed to 4'b1111 mid-frame -> stream stays 0,1,1,0. Second word accepted only at the next in_ready=1 edge. First bit of the second word appears exactly 6 cycles after the first bit of the first word (WIDTH+GAP_CYCLES+1).
5. rst_n=0 asserted during SHIFT bit index 1 -> D, bit_valid, busy, shift, in_ready go 0 without waiting for clk. No done pulse. After release, word 4'b1000/dir=0 sends 0,0,0,1 correctly.
6. Instance with GAP_CYCLES=0, WIDTH=8, in_data=8'hA5, dir=1 -> D=1,0,1,0,0,1,0,1. done and in_ready both 1 in the cycle after the last bit.
